alu_issue_stage: RTL and testbench

//  Decode-side counterpart of the Alu. Accepts RV32I ALU-class instructions with operand data and

---
 rtl/alu_issue_stage_if.sv | 72 +++++++
 rtl/alu_issue_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// ALU operation types and the issue-stage handshake interface.
// The out_illegal signal exists only when ALU_ISSUE_ILLEGAL_EN is defined.

package alu_pkg;

    typedef enum logic [3:0] {
        ALU_NULL = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SLL  = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic {
        ALU_UNSIGNED = 1'b0,
        ALU_SIGNED   = 1'b1
    } alu_sign_t;

    typedef struct packed {
        alu_op_t   operation;
        alu_sign_t signedness;
    } alu_mode_t;

endpackage

interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    import alu_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     insn;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    alu_mode_t       out_mode;
    logic [4:0]      out_rd;
    logic            out_we;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic            out_illegal;
`endif

    // Upstream/execute side (drives instructions, consumes bundles)
    modport master (
        output in_valid, insn, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_mode, out_rd, out_we
`ifdef ALU_ISSUE_ILLEGAL_EN
        , input out_illegal
`endif
    );

    // Issue stage side
    modport slave (
        input  in_valid, insn, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_mode, out_rd, out_we
`ifdef ALU_ISSUE_ILLEGAL_EN
        , output out_illegal
`endif
    );

endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32I ALU-class instructions into the registered
// {a, b, mode} bundle for the Alu, with rd/we, behind a 2-entry skid buffer.
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN adds the out_illegal flag.
//
// state  | meaning
// -------+-----------------------------------------------------------
// EMPTY  | no bundle held; out_valid=0, in_ready=1
// ONE    | main register holds the presented bundle; in_ready=1
// FULL   | main presented, skid holds the next bundle; in_ready=0

module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    alu_issue_stage_if.slave  bus
);

    if (XLEN != 32) begin : g_xlen_check
        $error("alu_issue_stage supports XLEN=32 only");
    end

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        alu_mode_t   mode;
        logic [4:0]  rd;
        logic        we;
`ifdef ALU_ISSUE_ILLEGAL_EN
        logic        illegal;
`endif
    } bundle_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t  state;
    bundle_t main_q;
    bundle_t skid_q;
    bundle_t dec;
    logic    out_valid_q;
    logic    in_ready_q;
    logic    accept;
    logic    consume;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        illegal;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    alu_op_t     dec_op;
    alu_sign_t   dec_sign;

    // Operation selected by funct3 alone (SUB/SRA variants handled by caller)
    function automatic alu_op_t base_op(input logic [2:0] fn3);
        case (fn3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLT;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    endfunction

    assign opcode = bus.insn[6:0];
    assign f3     = bus.insn[14:12];
    assign f7     = bus.insn[31:25];
    assign imm_i  = {{20{bus.insn[31]}}, bus.insn[31:20]};
    assign imm_u  = {bus.insn[31:12], 12'h000};
    assign shamt  = {27'd0, bus.insn[24:20]};

    // Instruction decode into the operand/mode bundle
    always_comb begin
        illegal  = 1'b0;
        dec_a    = '0;
        dec_b    = '0;
        dec_op   = ALU_NULL;
        dec_sign = ALU_SIGNED;
        case (opcode)
            OPC_OP: begin
                dec_a = bus.rs1_data;
                dec_b = bus.rs2_data;
                if (f7 == 7'h00) begin
                    dec_op = base_op(f3);
                end else if (f7 == 7'h20 && f3 == 3'b000) begin
                    dec_op = ALU_SUB;
                end else if (f7 == 7'h20 && f3 == 3'b101) begin
                    dec_op = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
                if (f3 == 3'b011) dec_sign = ALU_UNSIGNED;
            end
            OPC_OPIMM: begin
                dec_a  = bus.rs1_data;
                dec_b  = imm_i;
                dec_op = base_op(f3);
                if (f3 == 3'b001) begin
                    dec_b = shamt;
                    if (f7 != 7'h00) illegal = 1'b1;
                end else if (f3 == 3'b101) begin
                    dec_b = shamt;
                    if (f7 == 7'h20) dec_op = ALU_SRA;
                    else if (f7 != 7'h00) illegal = 1'b1;
                end
                if (f3 == 3'b011) dec_sign = ALU_UNSIGNED;
            end
            OPC_LUI: begin
                dec_b  = imm_u;
                dec_op = ALU_ADD;
            end
            OPC_AUIPC: begin
                dec_a  = bus.pc;
                dec_b  = imm_u;
                dec_op = ALU_ADD;
            end
            default: illegal = 1'b1;
        endcase

        // Illegal encodings collapse to an all-zero no-op bundle
        if (illegal) begin
            dec_a    = '0;
            dec_b    = '0;
            dec_op   = ALU_NULL;
            dec_sign = ALU_UNSIGNED;
        end

        dec                 = '0;
        dec.a               = dec_a;
        dec.b               = dec_b;
        dec.mode.operation  = dec_op;
        dec.mode.signedness = dec_sign;
        dec.rd              = bus.insn[11:7];
        dec.we              = !illegal && (bus.insn[11:7] != 5'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
        dec.illegal         = illegal;
`endif
    end

    assign accept  = bus.in_valid && in_ready_q;
    assign consume = out_valid_q && bus.out_ready;

    // Skid-buffer FSM with registered handshake outputs and bundle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_q      <= '0;
            skid_q      <= '0;
        end else if (flush) begin
            state       <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        main_q      <= dec;
                        state       <= S_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && consume) begin
                        main_q <= dec;
                    end else if (accept) begin
                        skid_q     <= dec;
                        state      <= S_FULL;
                        in_ready_q <= 1'b0;
                    end else if (consume) begin
                        state       <= S_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (consume) begin
                        main_q     <= skid_q;
                        state      <= S_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = main_q.a;
    assign bus.out_b     = main_q.b;
    assign bus.out_mode  = main_q.mode;
    assign bus.out_rd    = main_q.rd;
    assign bus.out_we    = main_q.we;
`ifdef ALU_ISSUE_ILLEGAL_EN
    assign bus.out_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a queue-based model of the
// two-entry buffer plus a mnemonic-level decoder, checked every cycle,
// and literal expectations for the directed cases.
// Honours ALU_ISSUE_ILLEGAL_EN when defined.

module tb_alu_issue_stage;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    alu_issue_stage_if #(.XLEN(32)) bus ();

    alu_issue_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        alu_op_t     op;
        alu_sign_t   sgn;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference decode from the instruction-set rules
    function automatic exp_t model_decode(input logic [31:0] i, input logic [31:0] pc,
                                          input logic [31:0] r1, input logic [31:0] r2);
        exp_t    e;
        alu_op_t tbl [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLT, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        logic [6:0] op7 = i[6:0];
        logic [2:0] f3  = i[14:12];
        logic [6:0] f7  = i[31:25];
        logic       shift;
        e.rd  = i[11:7];
        e.ill = 1'b1;
        e.a   = 0;
        e.b   = 0;
        e.op  = ALU_NULL;
        e.sgn = (f3 == 3'd3) ? ALU_UNSIGNED : ALU_SIGNED;
        if (op7 == 7'h37) begin
            e.ill = 0; e.a = 0; e.b = {i[31:12], 12'h0}; e.op = ALU_ADD; e.sgn = ALU_SIGNED;
        end else if (op7 == 7'h17) begin
            e.ill = 0; e.a = pc; e.b = {i[31:12], 12'h0}; e.op = ALU_ADD; e.sgn = ALU_SIGNED;
        end else if (op7 == 7'h33) begin
            e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            e.a = r1;
            e.b = r2;
            e.op = (f7 == 7'h20) ? ((f3 == 3'd0) ? ALU_SUB : ALU_SRA) : tbl[f3];
        end else if (op7 == 7'h13) begin
            shift = (f3 == 3'd1) || (f3 == 3'd5);
            e.ill = shift && !(f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20));
            e.a = r1;
            e.b = shift ? {27'd0, i[24:20]} : {{20{i[31]}}, i[31:20]};
            e.op = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : tbl[f3];
        end
        if (e.ill) begin
            e.a = 0; e.b = 0; e.op = ALU_NULL; e.we = 0;
        end else begin
            e.we = (e.rd != 0);
        end
        return e;
    endfunction

    // Buffer model: FIFO of depth two, flush wins, pop before push
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            logic acc, cons;
            acc  = bus.in_valid && (q.size() < 2);
            cons = bus.out_ready && (q.size() > 0);
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(model_decode(bus.insn, bus.pc, bus.rs1_data, bus.rs2_data));
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready", bus.in_ready, q.size() < 2);
            chk("out_valid", bus.out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("out_a", bus.out_a, q[0].a);
                chk("out_b", bus.out_b, q[0].b);
                chk("out_op", bus.out_mode.operation, q[0].op);
                if (!q[0].ill) begin
                    chk("out_sign", bus.out_mode.signedness, q[0].sgn);
                    chk("out_rd", bus.out_rd, q[0].rd);
                end
                chk("out_we", bus.out_we, q[0].we);
`ifdef ALU_ISSUE_ILLEGAL_EN
                chk("out_illegal", bus.out_illegal, q[0].ill);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        bus.in_valid = 1'b1;
        bus.insn     = i;
        bus.pc       = pc;
        bus.rs1_data = r1;
        bus.rs2_data = r2;
    endtask

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
    } vec_t;

    vec_t vecs [16] = '{
        '{32'hFFF00393, 32'h0, 32'h0,        32'h0},  // addi x7,x0,-1
        '{32'hFFE0A413, 32'h0, 32'h00000003, 32'h0},  // slti
        '{32'h0050B493, 32'h0, 32'hFFFFFFFF, 32'h0},  // sltiu
        '{32'h0020A533, 32'h0, 32'h5,        32'h6},  // slt
        '{32'h0020B5B3, 32'h0, 32'h7,        32'h8},  // sltu
        '{32'h00209633, 32'h0, 32'h1,        32'h3},  // sll
        '{32'h0020D6B3, 32'h0, 32'h100,      32'h2},  // srl
        '{32'h4020D733, 32'h0, 32'h80000000, 32'h1},  // sra
        '{32'h01F09793, 32'h0, 32'h1,        32'h0},  // slli 31
        '{32'h0010D813, 32'h0, 32'h2,        32'h0},  // srli 1
        '{32'hABCDE897, 32'h1000, 32'h0,     32'h0},  // auipc
        '{32'h00208033, 32'h0, 32'h1,        32'h2},  // add x0 -> we=0
        '{32'h022080B3, 32'h0, 32'h1,        32'h2},  // mul: illegal f7
        '{32'h40209133, 32'h0, 32'h1,        32'h2},  // f7=20 with sll: illegal
        '{32'h40109793, 32'h0, 32'h1,        32'h0},  // slli f7=20: illegal
        '{32'h0000A083, 32'h0, 32'h1,        32'h0}   // load: illegal
    };

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "bench timeout");
    end

    initial begin
        exp_t m;
        bit   acc;
        int   guard;
        int   cyc;

        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.insn      = '0;
        bus.pc        = '0;
        bus.rs1_data  = '0;
        bus.rs2_data  = '0;
        bus.out_ready = 1'b0;

        // Pin the reference decoder with hand-computed values
        m = model_decode(32'h00500093, 0, 0, 0);
        chk("model_addi_b", m.b, 32'd5);
        chk("model_addi_op", m.op, ALU_ADD);
        m = model_decode(32'h4040D193, 0, 32'h80000000, 0);
        chk("model_srai_op", m.op, ALU_SRA);
        chk("model_srai_b", m.b, 32'd4);
        m = model_decode(32'h0050B493, 0, 0, 0);
        chk("model_sltiu_sign", m.sgn, ALU_UNSIGNED);
        m = model_decode(32'h0000000B, 0, 0, 0);
        chk("model_illegal_we", m.we, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_a", bus.out_a, 32'd0);
        chk("rst_out_b", bus.out_b, 32'd0);
        chk("rst_mode", bus.out_mode, 5'd0);
        chk("rst_rd", bus.out_rd, 5'd0);
        chk("rst_we", bus.out_we, 1'b0);
`ifdef ALU_ISSUE_ILLEGAL_EN
        chk("rst_illegal", bus.out_illegal, 1'b0);
`endif
        reset = 1'b0;
        step();

        // addi x1,x0,5
        bus.out_ready = 1'b1;
        drive(32'h00500093, 0, 0, 0);
        step();
        bus.in_valid = 1'b0;
        chk("addi_valid", bus.out_valid, 1'b1);
        chk("addi_a", bus.out_a, 32'd0);
        chk("addi_b", bus.out_b, 32'd5);
        chk("addi_op", bus.out_mode.operation, ALU_ADD);
        chk("addi_rd", bus.out_rd, 5'd1);
        chk("addi_we", bus.out_we, 1'b1);
        step();

        // sub x2,x1,x2
        drive(32'h40208133, 0, 32'd9, 32'd4);
        step();
        bus.in_valid = 1'b0;
        chk("sub_a", bus.out_a, 32'd9);
        chk("sub_b", bus.out_b, 32'd4);
        chk("sub_op", bus.out_mode.operation, ALU_SUB);
        chk("sub_rd", bus.out_rd, 5'd2);
        chk("sub_we", bus.out_we, 1'b1);
        step();

        // srai then lui back-to-back
        drive(32'h4040D193, 0, 32'h80000000, 0);
        step();
        chk("srai_op", bus.out_mode.operation, ALU_SRA);
        chk("srai_sign", bus.out_mode.signedness, ALU_SIGNED);
        chk("srai_b", bus.out_b, 32'd4);
        chk("srai_a", bus.out_a, 32'h80000000);
        drive(32'h123450B7, 0, 32'hDEADBEEF, 0);
        step();
        bus.in_valid = 1'b0;
        chk("lui_a", bus.out_a, 32'd0);
        chk("lui_b", bus.out_b, 32'h12345000);
        chk("lui_op", bus.out_mode.operation, ALU_ADD);
        step();

        // Backpressure: three offered, two held, then drain in order
        bus.out_ready = 1'b0;
        drive(32'h0020C233, 0, 32'hF0, 32'h0F);
        step();
        drive(32'h0020E2B3, 0, 32'h11, 32'h22);
        step();
        drive(32'h0020F333, 0, 32'h33, 32'h44);
        step();
        chk("bp_in_ready", bus.in_ready, 1'b0);
        chk("bp_head_a", bus.out_a, 32'hF0);
        chk("bp_head_op", bus.out_mode.operation, ALU_XOR);
        bus.out_ready = 1'b1;
        step();
        chk("bp_second_a", bus.out_a, 32'h11);
        chk("bp_second_op", bus.out_mode.operation, ALU_OR);
        step();
        bus.in_valid = 1'b0;
        chk("bp_third_a", bus.out_a, 32'h33);
        chk("bp_third_op", bus.out_mode.operation, ALU_AND);
        step();
        chk("bp_drained", bus.out_valid, 1'b0);

        // Flush while FULL with a same-cycle input offer
        bus.out_ready = 1'b0;
        drive(32'h0020C233, 0, 32'h1, 32'h2);
        step();
        drive(32'h0020E2B3, 0, 32'h3, 32'h4);
        step();
        drive(32'h0020F333, 0, 32'h5, 32'h6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", bus.out_valid, 1'b0);
        chk("flush_ready", bus.in_ready, 1'b1);
        step();
        chk("flush_dropped", bus.out_valid, 1'b0);

        // Illegal opcode
        bus.out_ready = 1'b1;
        drive(32'h0000000B, 0, 32'h55, 32'h66);
        step();
        bus.in_valid = 1'b0;
        chk("ill_op", bus.out_mode.operation, ALU_NULL);
        chk("ill_we", bus.out_we, 1'b0);
        chk("ill_a", bus.out_a, 32'd0);
        chk("ill_b", bus.out_b, 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
        chk("ill_flag", bus.out_illegal, 1'b1);
`endif
        step();

        // Stream the table with a fixed stall pattern on out_ready
        cyc = 0;
        foreach (vecs[k]) begin
            drive(vecs[k].insn, vecs[k].pc, vecs[k].r1, vecs[k].r2);
            guard = 0;
            do begin
                acc = bus.in_ready;
                bus.out_ready = (cyc % 3) != 0;
                cyc++;
                step();
                guard++;
            end while (!acc && guard < 20);
            if (!acc) chk("stream_accept_timeout", 1'b0, 1'b1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) step();
        chk("stream_drained", bus.out_valid, 1'b0);

        // Reset while FULL discards both entries at once
        bus.out_ready = 1'b0;
        drive(32'h0020C233, 0, 32'h7, 32'h8);
        step();
        drive(32'h0020E2B3, 0, 32'h9, 32'hA);
        step();
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valid", bus.out_valid, 1'b0);
        chk("midrst_ready", bus.in_ready, 1'b1);
        chk("midrst_a", bus.out_a, 32'd0);
        step();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("midrst_nothing", bus.out_valid, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
